// File: rtl/instr_encoder_loader.sv
// Packs decoded ARM-subset instruction fields into 32-bit words and streams them into imem.
// Optional ENC_PAD_EN: after in_last, the remaining imem words are filled with NOP before DONE.
module instr_encoder_loader #(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Cond,
    input  logic [3:0]        Rn,
    input  logic [3:0]        Rd,
    input  logic [11:0]       Src2,
    input  logic [23:0]       Imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W-1:0] TOP_ADDR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [31:0]       NOP_WORD  = 32'hE1A0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef ENC_PAD_EN
        S_PAD,
`endif
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic              close_p1;

    function automatic logic [31:0] encode(
        input logic [3:0]  cond,
        input logic [1:0]  op,
        input logic [5:0]  funct,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [11:0] src2,
        input logic [23:0] imm24
    );
        logic [31:0] word;
        if (op == 2'b10)
            word = {cond, 2'b10, funct[5:4], imm24};
        else
            word = {cond, op, funct, rn, rd, src2};
        return word;
    endfunction

    // Stage p0: handshake and combinational encoding of the presented fields
    logic        xfer_p0;
    logic        legal_p0;
    logic        vld_p0;
    logic        at_top_p0;
    logic [31:0] enc_p0;

    assign xfer_p0   = in_valid && in_ready;
    assign legal_p0  = (Op != 2'b11);
    assign vld_p0    = xfer_p0 && legal_p0;
    assign at_top_p0 = (wptr == TOP_ADDR);
    assign enc_p0    = encode(Cond, Op, Funct, Rn, Rd, Src2, Imm24);

    // Stage p1: registered imem write and session control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wptr        <= '0;
            close_p1    <= 1'b0;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= 1'b0;

            if (imem_we)
                word_count <= word_count + COUNT_ONE;

            // The session's final write has just completed
            if (imem_we && close_p1) begin
                state    <= S_DONE;
                done     <= 1'b1;
                close_p1 <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state       <= S_LOAD;
                        wptr        <= BASE;
                        close_p1    <= 1'b0;
                        in_ready    <= 1'b1;
                        word_count  <= '0;
                        done        <= 1'b0;
                        err_illegal <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (vld_p0) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wptr;
                        imem_wdata <= enc_p0;
                        if (at_top_p0) begin
                            // Memory is now full; the counter stays at the top address
                            close_p1 <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            wptr <= wptr + ADDR_ONE;
                            if (in_last) begin
                                in_ready <= 1'b0;
`ifdef ENC_PAD_EN
                                state    <= S_PAD;
`else
                                close_p1 <= 1'b1;
`endif
                            end
                        end
                    end else if (xfer_p0) begin
                        err_illegal <= 1'b1;
                        if (in_last) begin
                            in_ready <= 1'b0;
`ifdef ENC_PAD_EN
                            state    <= S_PAD;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
`endif
                        end
                    end
                end

`ifdef ENC_PAD_EN
                S_PAD: begin
                    if (!close_p1) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wptr;
                        imem_wdata <= NOP_WORD;
                        if (at_top_p0)
                            close_p1 <= 1'b1;
                        else
                            wptr <= wptr + ADDR_ONE;
                    end
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: vector table for the main sessions plus
// hand-written sequences for reset abort, memory fill and (with ENC_PAD_EN) NOP padding.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_m, ls_s, ls_p;
  logic        in_valid, in_last;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Cond, Rn, Rd;
  logic [11:0] Src2;
  logic [23:0] Imm24;

  logic        m_rdy, m_we, m_done, m_err;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic [6:0]  m_wc;

  logic        s_rdy, s_we, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_wc;

  logic        p_rdy, p_we, p_done, p_err;
  logic [2:0]  p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_wc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) u_main (
    .clk(clk), .reset(reset), .load_start(ls_m), .in_valid(in_valid), .in_ready(m_rdy),
    .in_last(in_last), .Op(Op), .Funct(Funct), .Cond(Cond), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .Imm24(Imm24), .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
    .word_count(m_wc), .done(m_done), .err_illegal(m_err)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) u_small (
    .clk(clk), .reset(reset), .load_start(ls_s), .in_valid(in_valid), .in_ready(s_rdy),
    .in_last(in_last), .Op(Op), .Funct(Funct), .Cond(Cond), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .Imm24(Imm24), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .word_count(s_wc), .done(s_done), .err_illegal(s_err)
  );

  instr_encoder_loader #(.ADDR_W(3), .BASE_ADDR(0)) u_pad (
    .clk(clk), .reset(reset), .load_start(ls_p), .in_valid(in_valid), .in_ready(p_rdy),
    .in_last(in_last), .Op(Op), .Funct(Funct), .Cond(Cond), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .Imm24(Imm24), .imem_we(p_we), .imem_addr(p_addr), .imem_wdata(p_wdata),
    .word_count(p_wc), .done(p_done), .err_illegal(p_err)
  );

  typedef struct {
    logic        ls;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm;
    logic        last;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    ls_m     = v.ls;
    Cond     = 4'hE;
    Op       = v.op;
    Funct    = v.funct;
    Rn       = v.rn;
    Rd       = v.rd;
    Src2     = v.src2;
    Imm24    = v.imm;
    in_last  = v.last;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    ls_m     = 1'b0;
  endtask

  task automatic run_seq(input int lo, input int hi, input int exp_wc, input logic exp_err);
    ls_m = 1'b1;
    @(negedge clk);
    ls_m = 1'b0;
    check("start_ready", 32'(m_rdy), 32'd1);
    check("start_wc", 32'(m_wc), 32'd0);
    check("start_err", 32'(m_err), 32'd0);
    check("start_done", 32'(m_done), 32'd0);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      ls_m = 1'b0;
      check($sformatf("we_%0d", i), 32'(m_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        check($sformatf("addr_%0d", i), 32'(m_addr), 32'(tbl[i].addr));
        check($sformatf("wdata_%0d", i), m_wdata, tbl[i].data);
      end
      check($sformatf("ready_%0d", i), 32'(m_rdy), 32'(!tbl[i].last));
    end
    idle_inputs();
    @(negedge clk);
    check("end_done", 32'(m_done), 32'd1);
    check("end_wc", 32'(m_wc), 32'(exp_wc));
    check("end_err", 32'(m_err), 32'(exp_err));
    check("end_ready", 32'(m_rdy), 32'd0);
    check("end_we", 32'(m_we), 32'd0);
  endtask

  initial begin
    //          ls  op     funct      rn  rd  src2    imm         last we addr data
    tbl[0] = '{1'b0, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h000000, 1'b1, 1'b1, 6'd0, 32'hE2821005};
    tbl[1] = '{1'b0, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h000000, 1'b0, 1'b1, 6'd0, 32'hE5943008};
    tbl[2] = '{1'b1, 2'b01, 6'b011000, 4'd4, 4'd3, 12'h008, 24'h000000, 1'b0, 1'b1, 6'd1, 32'hE5843008};
    tbl[3] = '{1'b0, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000002, 1'b1, 1'b1, 6'd2, 32'hEA000002};
    tbl[4] = '{1'b0, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h000000, 1'b0, 1'b1, 6'd0, 32'hE2821005};
    tbl[5] = '{1'b0, 2'b11, 6'b111111, 4'd7, 4'd7, 12'hFFF, 24'h000000, 1'b0, 1'b0, 6'd0, 32'h00000000};
    tbl[6] = '{1'b0, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h000000, 1'b1, 1'b1, 6'd1, 32'hE5943008};
    tbl[7] = '{1'b0, 2'b10, 6'b100000, 4'd0, 4'd0, 12'h000, 24'h000002, 1'b1, 1'b1, 6'd0, 32'hEA000002};

    reset = 1'b1;
    ls_s = 1'b0;
    ls_p = 1'b0;
    idle_inputs();
    Cond = 4'hE; Op = 2'b00; Funct = '0; Rn = '0; Rd = '0; Src2 = '0; Imm24 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(m_rdy), 32'd0);
    check("rst_we", 32'(m_we), 32'd0);
    check("rst_addr", 32'(m_addr), 32'd0);
    check("rst_wdata", m_wdata, 32'd0);
    check("rst_wc", 32'(m_wc), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // in_valid while IDLE is not a transfer
    drive(tbl[4]);
    @(negedge clk);
    check("idle_we", 32'(m_we), 32'd0);
    check("idle_err", 32'(m_err), 32'd0);
    idle_inputs();

    run_seq(0, 0, 1, 1'b0);
    run_seq(1, 3, 3, 1'b0);
    run_seq(4, 6, 2, 1'b1);

    // DONE ignores beats, including illegal ones
    drive(tbl[5]);
    @(negedge clk);
    drive(tbl[4]);
    @(negedge clk);
    check("done_ign_we", 32'(m_we), 32'd0);
    check("done_ign_wc", 32'(m_wc), 32'd2);
    check("done_ign_done", 32'(m_done), 32'd1);
    idle_inputs();

    run_seq(0, 0, 1, 1'b0);

    // Reset while the second beat's write is on the port
    ls_m = 1'b1;
    @(negedge clk);
    ls_m = 1'b0;
    drive(tbl[4]);
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    idle_inputs();
    check("pre_rst_we", 32'(m_we), 32'd1);
    check("pre_rst_addr", 32'(m_addr), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(m_we), 32'd0);
    check("mid_rst_addr", 32'(m_addr), 32'd0);
    check("mid_rst_wdata", m_wdata, 32'd0);
    check("mid_rst_wc", 32'(m_wc), 32'd0);
    check("mid_rst_ready", 32'(m_rdy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_seq(7, 7, 1, 1'b0);

    // Fill a 4-word memory without in_last
    ls_s = 1'b1;
    @(negedge clk);
    ls_s = 1'b0;
    drive(tbl[4]);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("fill_we_%0d", k), 32'(s_we), 32'(k < 4));
      if (k < 4) begin
        check($sformatf("fill_addr_%0d", k), 32'(s_addr), 32'(k));
        check($sformatf("fill_wdata_%0d", k), s_wdata, 32'hE2821005);
      end
      check($sformatf("fill_ready_%0d", k), 32'(s_rdy), 32'(k < 3));
      check($sformatf("fill_done_%0d", k), 32'(s_done), 32'(k >= 4));
      check($sformatf("fill_wc_%0d", k), 32'(s_wc), 32'((k < 4) ? k : 4));
    end
    idle_inputs();
    check("fill_err", 32'(s_err), 32'd0);

    // Two words with in_last into an 8-word memory
    ls_p = 1'b1;
    @(negedge clk);
    ls_p = 1'b0;
    drive(tbl[4]);
    for (int k = 0; k < 10; k++) begin
      logic        e_we;
      logic        e_done;
      logic [31:0] e_data;
      int          e_wc;
      @(negedge clk);
      if (k == 0) drive(tbl[6]);
      if (k == 1) idle_inputs();
`ifdef ENC_PAD_EN
      e_we   = (k <= 7);
      e_done = (k >= 8);
      e_wc   = (k < 8) ? k : 8;
`else
      e_we   = (k <= 1);
      e_done = (k >= 2);
      e_wc   = (k < 2) ? k : 2;
`endif
      e_data = (k == 0) ? 32'hE2821005 : ((k == 1) ? 32'hE5943008 : 32'hE1A00000);
      check($sformatf("pad_we_%0d", k), 32'(p_we), 32'(e_we));
      if (e_we) begin
        check($sformatf("pad_addr_%0d", k), 32'(p_addr), 32'(k));
        check($sformatf("pad_wdata_%0d", k), p_wdata, e_data);
      end
      check($sformatf("pad_ready_%0d", k), 32'(p_rdy), 32'(k == 0));
      check($sformatf("pad_done_%0d", k), 32'(p_done), 32'(e_done));
      check($sformatf("pad_wc_%0d", k), 32'(p_wc), 32'(e_wc));
    end
    check("pad_err", 32'(p_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the pipelined processor's main decoder.
- Accepts decoded instruction fields over a valid/ready handshake, packs each into a 32-bit ARM-subset instruction word, and writes the words sequentially into instruction memory through a write port.
- Used to load test programs into imem before the core is released from reset. It sits between the bench or host loader and the imem write port.

Parameters:
- ADDR_W, 6, imem word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address of the first write after load_start.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  single-cycle pulse that begins a load session.
- in_valid  input  1  instruction fields are valid.
- in_ready  output  1  block accepts fields this cycle.
- in_last  input  1  marks the final instruction of the session.
- Op  input  2  instruction class: 00 DP, 01 memory, 10 branch, 11 illegal.
- Funct  input  6  DP: {I,cmd[3:0],S}; memory: {~I,P,U,B,W,L}; branch: only [5:4] used, as {1,L}.
- Cond  input  4  condition field.
- Rn  input  4  first source register.
- Rd  input  4  destination register.
- Src2  input  12  immediate or register operand field for DP and memory.
- Imm24  input  24  branch offset.
- imem_we  output  1  imem write strobe.
- imem_addr  output  ADDR_W  imem word address.
- imem_wdata  output  32  encoded instruction word.
- word_count  output  ADDR_W+1  words written this session.
- done  output  1  high while in DONE.
- err_illegal  output  1  sticky flag; an Op=11 beat was received.

Behaviour:
- Reset: state IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0, done=0, err_illegal=0. Reset mid-load aborts the session. Words already written to imem stay there.
- Encoding, Op 00/01: {Cond,Op,Funct,Rn,Rd,Src2}.
- Encoding, Op 10: {Cond,2'b10,Funct[5:4],Imm24}.
- Op 11: no encoding.
- IDLE: in_ready=0. load_start moves to LOAD, loads the address counter with BASE_ADDR, clears word_count and err_illegal.
- LOAD: in_ready=1 unless full. A beat transfers when in_valid && in_ready.
- Write timing: a legal beat produces a registered write on the next cycle. imem_we=1 for exactly one cycle with the current counter address and the encoded word. The counter then increments and word_count increments.
- Throughput: one beat per cycle, back-to-back, no bubbles.
- Illegal beat (Op=11): handshake completes, no write, counter unchanged, err_illegal set.
- Full: the counter reaching 2^ADDR_W-1 and being written sets full. Full forces in_ready=0 from the following cycle and transitions to DONE after the write. Counter never wraps.
- in_last on an accepted beat transitions to DONE after its write, or immediately if that beat is illegal.
- in_last on the beat that fills memory causes a single transition to DONE.
- DONE: done=1, in_ready=0. load_start restarts exactly as from IDLE. All other inputs are ignored.
- load_start while in LOAD is ignored.
- in_valid while in IDLE or DONE is ignored: no transfer, no error.

Optional Feature:
- Macro: ENC_PAD_EN.
- Defined: on in_last, the block enters PAD instead of DONE. PAD holds in_ready=0 and writes NOP 0xE1A00000 one word per cycle to every remaining address up to 2^ADDR_W-1. word_count counts the pad words. DONE is entered after the top address is written. Reset or full behaviour is unchanged. A fill via full skips PAD.
- Undefined: no PAD state; in_last goes directly to DONE.

Test Plan:
- Reset, load_start, then Cond=E Op=00 Funct=101000 Rn=2 Rd=1 Src2=005 with in_last -> the next cycle shows imem_we=1, addr 0, wdata 0xE2821005; then done=1 and word_count=1.
- Back-to-back beats: LDR (Op=01 Funct=011001 Rn=4 Rd=3 Src2=008), then STR (Funct=011000), then B (Op=10 Funct=100000 Imm24=000002, last) -> consecutive writes E5943008@0, E5843008@1, EA000002@2; word_count=3.
- An Op=11 beat between two legal beats -> err_illegal=1, only two writes at addresses 0 and 1; a new load_start clears err_illegal.
- With ADDR_W=2, stream 6 beats without in_last -> writes at 0..3 only, in_ready=0 after the 4th write, done=1, word_count=4, no wrap to 0.
- Assert reset during the write of the second beat -> all outputs zero immediately; load_start restarts at BASE_ADDR.
- With ENC_PAD_EN and ADDR_W=3, load 2 words with last -> writes 0xE1A00000 at addresses 2..7 on consecutive cycles, then done=1, word_count=8.
